// File: rtl/menu_config_nav.sv
// Menu navigator: walks NUM_FIELDS setting fields, moves a cursor with arrow keys
// (including auto-repeat), and commits one one-hot selection per field.
module menu_config_nav #(
    parameter int                      NUM_FIELDS    = 4,
    parameter int                      MAX_OPTS      = 16,
    parameter logic [8*NUM_FIELDS-1:0] FIELD_OPTS    = 32'h10_04_02_06,
    parameter bit                      WRAP          = 1'b1,
    parameter int                      HOLD_CYCLES   = 25_000_000,
    parameter int                      REPEAT_CYCLES = 5_000_000,
    localparam int                     FW            = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
    localparam int                     CW            = $clog2(MAX_OPTS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           right_arrow_pressed,
    input  logic                           left_arrow_pressed,
    input  logic                           back_pressed,
    input  logic                           enter_pressed,
    output logic                           menu_active,
    output logic [FW-1:0]                  field_idx,
    output logic [CW-1:0]                  cursor,
    output logic [NUM_FIELDS*MAX_OPTS-1:0] sel_onehot,
    output logic                           config_valid,
    output logic                           done
);

    localparam int                 RW      = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
    localparam logic [RW-1:0]      HOLD_V  = RW'(HOLD_CYCLES);
    localparam logic [RW-1:0]      REP_END = RW'(HOLD_CYCLES + REPEAT_CYCLES);
    localparam logic [FW-1:0]      LAST_F  = FW'(NUM_FIELDS - 1);
    localparam logic [MAX_OPTS-1:0] OPT0   = MAX_OPTS'(1);

    typedef enum logic [1:0] {IDLE, BROWSE, DONE} state_t;

    state_t        state;
    logic          start_q, right_q, left_q, back_q, enter_q;
    logic          start_qq, right_qq, left_qq, back_qq, enter_qq;
    logic [RW-1:0] rep_cnt;

    logic          start_ev, right_ev, left_ev, back_ev, enter_ev;
    logic          held_right, held_left, rep_fire, step_up, step_dn;
    logic [RW-1:0] rep_next;
    logic [7:0]    cur_opts;
    logic [CW-1:0] cur_last, cur_up, cur_dn;
    logic [CW-1:0] field_enc [NUM_FIELDS];

    // Two-stage key pipeline: the second stage lets us see 0->1 transitions.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {start_q, right_q, left_q, back_q, enter_q}      <= '0;
            {start_qq, right_qq, left_qq, back_qq, enter_qq} <= '0;
        end else begin
            {start_q, right_q, left_q, back_q, enter_q} <=
                {start, right_arrow_pressed, left_arrow_pressed, back_pressed, enter_pressed};
            {start_qq, right_qq, left_qq, back_qq, enter_qq} <=
                {start_q, right_q, left_q, back_q, enter_q};
        end
    end

    always_comb begin
        start_ev   = start_q & ~start_qq;
        right_ev   = right_q & ~right_qq;
        left_ev    = left_q & ~left_qq;
        back_ev    = back_q & ~back_qq;
        enter_ev   = enter_q & ~enter_qq;
        held_right = right_q & ~left_q;
        held_left  = left_q & ~right_q;
        rep_next   = rep_cnt + 1'b1;
        rep_fire   = (held_right | held_left) & ((rep_next == HOLD_V) | (rep_next == REP_END));
        step_up    = (right_ev & ~left_ev) | (rep_fire & held_right);
        step_dn    = (left_ev & ~right_ev) | (rep_fire & held_left);

        cur_opts = FIELD_OPTS[8*field_idx +: 8];
        cur_last = CW'(cur_opts - 8'd1);

        if (cursor == cur_last) cur_up = WRAP ? '0 : cursor;
        else                    cur_up = cursor + 1'b1;
        if (cursor == '0)       cur_dn = WRAP ? cur_last : '0;
        else                    cur_dn = cursor - 1'b1;
    end

    // Index of each field's committed option, used to reload the cursor.
    always_comb begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
            field_enc[f] = '0;
            for (int b = 0; b < MAX_OPTS; b++) begin
                if (sel_onehot[MAX_OPTS*f + b]) field_enc[f] = CW'(b);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            menu_active  <= 1'b0;
            field_idx    <= '0;
            cursor       <= '0;
            sel_onehot   <= {NUM_FIELDS{OPT0}};
            config_valid <= 1'b0;
            done         <= 1'b0;
            rep_cnt      <= '0;
        end else begin
            done        <= 1'b0;
            menu_active <= (state == BROWSE);
            case (state)
                IDLE: begin
                    rep_cnt <= '0;
                    if (start_ev) begin
                        state        <= BROWSE;
                        field_idx    <= '0;
                        cursor       <= field_enc[0];
                        config_valid <= 1'b0;
                    end
                end
                BROWSE: begin
                    if (enter_ev) begin
                        rep_cnt <= '0;
                        sel_onehot[MAX_OPTS*field_idx +: MAX_OPTS] <= OPT0 << cursor;
                        if (field_idx == LAST_F) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            config_valid <= 1'b1;
                        end else begin
                            field_idx <= field_idx + 1'b1;
                            cursor    <= field_enc[field_idx + 1'b1];
                        end
                    end else if (back_ev) begin
                        rep_cnt <= '0;
                        if (field_idx != '0) begin
                            field_idx <= field_idx - 1'b1;
                            cursor    <= field_enc[field_idx - 1'b1];
                        end
                    end else begin
                        if (step_up)      cursor <= cur_up;
                        else if (step_dn) cursor <= cur_dn;
                        // After the hold delay the counter cycles HOLD..HOLD+REPEAT.
                        if (!(held_right | held_left) || right_ev || left_ev) rep_cnt <= '0;
                        else if (rep_next == REP_END)                         rep_cnt <= HOLD_V;
                        else                                                  rep_cnt <= rep_next;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    rep_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_menu_config_nav.sv
// Self-checking bench for menu_config_nav: a wrapping and a saturating instance
// share stimulus and are compared every cycle against an option-index model.
module tb_menu_config_nav;

    localparam int HOLD = 10;
    localparam int REP  = 4;

    logic        clock, reset;
    logic        start, right, left, back, enter;
    logic        a_menu_active, b_menu_active, a_config_valid, b_config_valid, a_done, b_done;
    logic [1:0]  a_field_idx, b_field_idx;
    logic [3:0]  a_cursor, b_cursor;
    logic [63:0] a_sel, b_sel;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    menu_config_nav #(.WRAP(1'b1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut_a (
        .clock(clock), .reset(reset), .start(start),
        .right_arrow_pressed(right), .left_arrow_pressed(left),
        .back_pressed(back), .enter_pressed(enter),
        .menu_active(a_menu_active), .field_idx(a_field_idx), .cursor(a_cursor),
        .sel_onehot(a_sel), .config_valid(a_config_valid), .done(a_done)
    );

    menu_config_nav #(.WRAP(1'b0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut_b (
        .clock(clock), .reset(reset), .start(start),
        .right_arrow_pressed(right), .left_arrow_pressed(left),
        .back_pressed(back), .enter_pressed(enter),
        .menu_active(b_menu_active), .field_idx(b_field_idx), .cursor(b_cursor),
        .sel_onehot(b_sel), .config_valid(b_config_valid), .done(b_done)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Model state: selections are kept as option indices, not one-hot vectors.
    int opts [4]    = '{6, 2, 4, 16};
    bit wrap_of [2] = '{1'b1, 1'b0};
    int m_state [2];
    int m_field [2];
    int m_cursor [2];
    int m_sel [2][4];
    bit m_cv [2];
    bit m_done [2];
    bit m_active [2];
    int m_held [2];
    bit q_s, q_r, q_l, q_b, q_e, qq_s, qq_r, qq_l, qq_b, qq_e;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k]  = 0;
            m_field[k]  = 0;
            m_cursor[k] = 0;
            m_cv[k]     = 0;
            m_done[k]   = 0;
            m_active[k] = 0;
            m_held[k]   = 0;
            for (int f = 0; f < 4; f++) m_sel[k][f] = 0;
        end
        {q_s, q_r, q_l, q_b, q_e, qq_s, qq_r, qq_l, qq_b, qq_e} = '0;
    endtask

    function automatic int move(input int cur, input int dir, input int n, input bit wrap);
        int t = cur + dir;
        if (wrap) return (t + n) % n;
        if (t < 0) return 0;
        if (t > n - 1) return n - 1;
        return t;
    endfunction

    task automatic model_step(input int k);
        bit ev_s, ev_r, ev_l, ev_b, ev_e, held_r, held_l;
        int dir;
        ev_s = q_s && !qq_s;
        ev_r = q_r && !qq_r;
        ev_l = q_l && !qq_l;
        ev_b = q_b && !qq_b;
        ev_e = q_e && !qq_e;
        held_r = q_r && !q_l;
        held_l = q_l && !q_r;
        m_done[k]   = 0;
        m_active[k] = (m_state[k] == 1);
        case (m_state[k])
            0: begin
                m_held[k] = 0;
                if (ev_s) begin
                    m_state[k]  = 1;
                    m_field[k]  = 0;
                    m_cursor[k] = m_sel[k][0];
                    m_cv[k]     = 0;
                end
            end
            1: begin
                if (ev_e) begin
                    m_held[k] = 0;
                    m_sel[k][m_field[k]] = m_cursor[k];
                    if (m_field[k] == 3) begin
                        m_state[k] = 2;
                        m_done[k]  = 1;
                        m_cv[k]    = 1;
                    end else begin
                        m_field[k]  = m_field[k] + 1;
                        m_cursor[k] = m_sel[k][m_field[k]];
                    end
                end else if (ev_b) begin
                    m_held[k] = 0;
                    if (m_field[k] > 0) begin
                        m_field[k]  = m_field[k] - 1;
                        m_cursor[k] = m_sel[k][m_field[k]];
                    end
                end else begin
                    dir = 0;
                    if (ev_r && !ev_l) dir = 1;
                    else if (ev_l && !ev_r) dir = -1;
                    if (ev_r || ev_l || !(held_r || held_l)) begin
                        m_held[k] = 0;
                    end else begin
                        m_held[k]++;
                        if (m_held[k] == HOLD || (m_held[k] > HOLD && (m_held[k] - HOLD) % REP == 0))
                            dir = held_r ? 1 : -1;
                    end
                    if (dir != 0) m_cursor[k] = move(m_cursor[k], dir, opts[m_field[k]], wrap_of[k]);
                end
            end
            default: begin
                m_state[k] = 0;
                m_held[k]  = 0;
            end
        endcase
    endtask

    function automatic logic [63:0] model_sel(input int k);
        logic [63:0] r = '0;
        for (int f = 0; f < 4; f++) r[16*f + m_sel[k][f]] = 1'b1;
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                model_reset();
            end else begin
                model_step(0);
                model_step(1);
                {qq_s, qq_r, qq_l, qq_b, qq_e} = {q_s, q_r, q_l, q_b, q_e};
                {q_s, q_r, q_l, q_b, q_e} = {start, right, left, back, enter};
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                check_output("cmp_a_active", a_menu_active, m_active[0]);
                check_output("cmp_a_field", a_field_idx, m_field[0]);
                check_output("cmp_a_cursor", a_cursor, m_cursor[0]);
                check_output("cmp_a_sel", a_sel, model_sel(0));
                check_output("cmp_a_valid", a_config_valid, m_cv[0]);
                check_output("cmp_a_done", a_done, m_done[0]);
                check_output("cmp_b_active", b_menu_active, m_active[1]);
                check_output("cmp_b_field", b_field_idx, m_field[1]);
                check_output("cmp_b_cursor", b_cursor, m_cursor[1]);
                check_output("cmp_b_sel", b_sel, model_sel(1));
                check_output("cmp_b_valid", b_config_valid, m_cv[1]);
                check_output("cmp_b_done", b_done, m_done[1]);
            end
        end
    end

    // Drives the selected keys high for one cycle, then waits for the cursor update.
    task automatic apply_stimulus(input bit s, input bit r, input bit l, input bit b, input bit e);
        {start, right, left, back, enter} = {s, r, l, b, e};
        @(posedge clock);
        #1 {start, right, left, back, enter} = '0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    int la [3]  = '{5, 4, 3};
    int ra [8]  = '{4, 5, 0, 1, 2, 3, 4, 5};
    int rb [8]  = '{1, 2, 3, 4, 5, 5, 5, 5};
    int l2 [3]  = '{4, 3, 2};
    int he [8]  = '{1, 11, 12, 15, 16, 19, 20, 24};
    int hv [8]  = '{0, 1, 2, 2, 3, 3, 4, 4};

    initial begin
        reset = 0;
        {start, right, left, back, enter} = '0;
        @(posedge clock);
        cmp_en = 1;
        repeat (2) @(posedge clock);
        #1;
        check_output("rst_active", a_menu_active, 0);
        check_output("rst_field", a_field_idx, 0);
        check_output("rst_cursor", a_cursor, 0);
        check_output("rst_sel", a_sel, 64'h0001_0001_0001_0001);
        check_output("rst_valid", a_config_valid, 0);
        check_output("rst_done", a_done, 0);
        reset = 1;

        @(posedge clock);
        #1 start = 1;
        @(posedge clock);
        #1 start = 0;
        @(posedge clock);
        #1 check_output("active_cycle2", a_menu_active, 0);
        @(posedge clock);
        #1 check_output("active_cycle3", a_menu_active, 1);
        check_output("open_field", a_field_idx, 0);
        check_output("open_cursor", a_cursor, 0);
        check_output("open_valid", a_config_valid, 0);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 1, 0, 0);
            check_output("wrap_left", a_cursor, la[i]);
            check_output("sat_left", b_cursor, 0);
        end
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 1, 0, 0, 0);
            check_output("wrap_right", a_cursor, ra[i]);
            check_output("sat_right", b_cursor, rb[i]);
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 1, 0, 0);
            check_output("left_a", a_cursor, l2[i]);
            check_output("left_b", b_cursor, l2[i]);
        end

        apply_stimulus(0, 1, 0, 0, 1);
        check_output("enter_right_field", a_field_idx, 1);
        check_output("enter_right_cursor", a_cursor, 0);
        check_output("commit_f0", a_sel[15:0], 16'h0004);

        apply_stimulus(0, 0, 1, 0, 0);
        check_output("f1_wrap_left", a_cursor, 1);
        check_output("f1_sat_left", b_cursor, 0);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("commit_f1_a", a_sel[31:16], 16'h0002);
        check_output("commit_f1_b", b_sel[31:16], 16'h0001);

        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 0);
        check_output("f2_cursor", a_cursor, 3);
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("back_field", a_field_idx, 1);
        check_output("back_cursor_a", a_cursor, 1);
        check_output("back_cursor_b", b_cursor, 0);
        check_output("back_f2_kept", a_sel[47:32], 16'h0001);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("refwd_cursor", a_cursor, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1);
        check_output("f3_field", a_field_idx, 3);
        check_output("commit_f2", a_sel[47:32], 16'h0008);

        right = 1;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clock);
            #1;
            if (e == 20) right = 0;
            for (int j = 0; j < 8; j++) begin
                if (he[j] == e) begin
                    check_output("hold_a", a_cursor, hv[j]);
                    check_output("hold_b", b_cursor, hv[j]);
                end
            end
        end

        for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, 0, 0);
        check_output("f3_cursor", a_cursor, 9);
        enter = 1;
        @(posedge clock);
        #1 enter = 0;
        check_output("done_early", a_done, 0);
        @(posedge clock);
        #1 check_output("done_pulse", a_done, 1);
        check_output("done_valid", a_config_valid, 1);
        check_output("final_sel_a", a_sel, 64'h0200_0008_0002_0004);
        check_output("final_sel_b", b_sel, 64'h0200_0008_0001_0004);
        @(posedge clock);
        #1 check_output("done_cleared", a_done, 0);
        check_output("valid_held", a_config_valid, 1);
        check_output("idle_inactive", a_menu_active, 0);

        apply_stimulus(1, 0, 0, 0, 0);
        check_output("restart_valid", a_config_valid, 0);
        check_output("restart_cursor", a_cursor, 2);
        check_output("restart_active", a_menu_active, 1);

        apply_stimulus(0, 1, 0, 0, 0);
        check_output("pre_reset_cursor", a_cursor, 3);
        #2 reset = 0;
        #1;
        check_output("async_cursor", a_cursor, 0);
        check_output("async_active", a_menu_active, 0);
        check_output("async_sel", a_sel, 64'h0001_0001_0001_0001);
        check_output("async_valid", a_config_valid, 0);
        check_output("async_field", a_field_idx, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1;
        repeat (3) @(posedge clock);
        #1;
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
